// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, reset vector,
// NOP encoding and address alignment.
package fetch_pkg;

   localparam int FETCH_XLEN = 32;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_KILL = 2'd2
   } fetch_state_t;

   localparam logic [FETCH_XLEN-1:0] FETCH_RESET_ADDR = 32'h0000_0000;
   localparam logic [FETCH_XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

   function automatic logic [FETCH_XLEN-1:0] align4(input logic [FETCH_XLEN-1:0] a);
      return {a[FETCH_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/grant/response bundle between fetch and imem.
interface fetch_ctrl_if #(
   parameter int XLEN = 32
) ();

   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/fetch_buf.sv
// One-entry fetch buffer toward Decode: captures a returned instruction and
// its PC, holds it under stall, and drops it on consume or flush.
module fetch_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            capture,
   input  logic            consume,
   input  logic            flush,
   input  logic [XLEN-1:0] instr_d,
   input  logic [XLEN-1:0] pc_d,
   output logic            valid_q,
   output logic [XLEN-1:0] instr_q,
   output logic [XLEN-1:0] pc_q
);

   // flush wins over a same-cycle capture so a killed fetch never becomes visible
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (capture) begin
            valid_q <= 1'b1;
         end else if (consume) begin
            valid_q <= 1'b0;
         end
         if (capture && !flush) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one outstanding imem request at a
// time, handles branch/trap redirects and feeds a one-entry buffer to Decode.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int              XLEN       = FETCH_XLEN,
   parameter logic [XLEN-1:0] RESET_ADDR = FETCH_RESET_ADDR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid_i,
   input  logic [XLEN-1:0]   redirect_addr_i,
   input  logic              trap_valid_i,
   input  logic [XLEN-1:0]   trap_addr_i,
   input  logic              stall_d_i,
   fetch_ctrl_if.master      imem,
   output logic              instr_valid_o,
   output logic [XLEN-1:0]   instr_o,
   output logic [XLEN-1:0]   instr_pc_o,
   output logic [XLEN-1:0]   pc_plus4_o,
   output logic              flush_d_o
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] target;
   logic            redir;
   logic            fire;
   logic            capture;
   logic            consume;

   assign redir     = trap_valid_i | redirect_valid_i;
   assign target    = align4(trap_valid_i ? trap_addr_i : redirect_addr_i);
   assign flush_d_o = redir;

   // Only request when the buffer is free or draining, so a response always lands in an empty buffer
   assign imem.req  = (state_q == S_REQ) & (!instr_valid_o | !stall_d_i) & !reset;
   assign imem.addr = pc_q;
   assign fire      = imem.req & imem.gnt;
   assign consume   = instr_valid_o & !stall_d_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_ADDR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      capture = 1'b0;
      case (state_q)
         S_REQ: begin
            if (fire) begin
               state_d = redir ? S_KILL : S_WAIT;
            end
            if (redir) begin
               pc_d = target;
            end
         end
         S_WAIT: begin
            if (imem.rvalid) begin
               state_d = S_REQ;
               if (redir) begin
                  pc_d = target;
               end else begin
                  capture = 1'b1;
                  pc_d    = pc_q + XLEN'(4);
               end
            end else if (redir) begin
               pc_d    = target;
               state_d = S_KILL;
            end
         end
         S_KILL: begin
            // the response still owed for the abandoned request is swallowed here
            if (imem.rvalid) begin
               state_d = S_REQ;
            end
            if (redir) begin
               pc_d = target;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   fetch_buf #(
      .XLEN (XLEN)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .capture (capture),
      .consume (consume),
      .flush   (redir),
      .instr_d (imem.rdata),
      .pc_d    (pc_q),
      .valid_q (instr_valid_o),
      .instr_q (instr_o),
      .pc_q    (instr_pc_o)
   );

   assign pc_plus4_o = instr_pc_o + XLEN'(4);

   a_no_rvalid_in_req: assert property (
      @(posedge clk) disable iff (reset) !((state_q == S_REQ) && imem.rvalid)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed-vector bench for fetch_ctrl: cycle table for fetch, stall, redirect,
// trap priority, alignment and wrap, plus a hand-written async reset sequence.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid_i = 1'b0;
   logic [31:0] redirect_addr_i = '0;
   logic        trap_valid_i = 1'b0;
   logic [31:0] trap_addr_i = '0;
   logic        stall_d_i = 1'b0;
   logic        instr_valid_o;
   logic [31:0] instr_o, instr_pc_o, pc_plus4_o;
   logic        flush_d_o;

   int checks = 0;
   int failures = 0;

   fetch_ctrl_if #(.XLEN(32)) imem ();

   fetch_ctrl #(.XLEN(32), .RESET_ADDR(32'h0000_0000)) dut (
      .clk              (clk),
      .reset            (reset),
      .redirect_valid_i (redirect_valid_i),
      .redirect_addr_i  (redirect_addr_i),
      .trap_valid_i     (trap_valid_i),
      .trap_addr_i      (trap_addr_i),
      .stall_d_i        (stall_d_i),
      .imem             (imem),
      .instr_valid_o    (instr_valid_o),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o),
      .pc_plus4_o       (pc_plus4_o),
      .flush_d_o        (flush_d_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        stall;
      logic        redir;
      logic [31:0] raddr;
      logic        trap;
      logic [31:0] taddr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_vld;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
      logic        e_flush;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic gnt, input logic rvalid,
                               input logic [31:0] rdata, input logic stall, input logic redir,
                               input logic [31:0] raddr, input logic trap, input logic [31:0] taddr,
                               input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                               input logic [31:0] e_instr, input logic [31:0] e_pc,
                               input logic [31:0] e_pc4, input logic e_flush);
      vec_t v;
      v.name = name; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.stall = stall;
      v.redir = redir; v.raddr = raddr; v.trap = trap; v.taddr = taddr;
      v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_instr = e_instr;
      v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_flush = e_flush;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
      stall_d_i = 1'b0; redirect_valid_i = 1'b0; redirect_addr_i = '0;
      trap_valid_i = 1'b0; trap_addr_i = '0;
   endtask

   localparam logic [31:0] I0 = 32'h1111_0001, I1 = 32'h2222_0002, I2 = 32'h3333_0003;
   localparam logic [31:0] I4 = 32'h4444_0004, JUNK = 32'h5555_0005, I5 = 32'h6666_0006;
   localparam logic [31:0] I6 = 32'h7777_0007, I7 = 32'h8888_0008;

   initial begin
      //                 name            gnt rv rdata         st rd raddr         tr taddr  | req addr          vld instr      pc            pc4           fl
      vecs.push_back(mk("fetch0_req",    1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h0,        0, 0,         0,            0,            0));
      vecs.push_back(mk("fetch0_rsp",    0, 1, I0,           0, 0, 0,            0, 0,       0, 32'h0,        0, 0,         0,            0,            0));
      vecs.push_back(mk("fetch4_req",    1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h4,        1, I0,        32'h0,        32'h4,        0));
      vecs.push_back(mk("fetch4_rsp",    0, 1, I1,           0, 0, 0,            0, 0,       0, 32'h4,        0, 0,         0,            0,            0));
      vecs.push_back(mk("fetch8_req",    1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h8,        1, I1,        32'h4,        32'h8,        0));
      vecs.push_back(mk("fetch8_rsp",    0, 1, I2,           0, 0, 0,            0, 0,       0, 32'h8,        0, 0,         0,            0,            0));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk($sformatf("stall%0d", k), 0, 0, 0, 1, 0, 0, 0, 0,           0, 32'hC,        1, I2,        32'h8,        32'hC,        0));
      vecs.push_back(mk("stall_fall",    1, 0, 0,            0, 0, 0,            0, 0,       1, 32'hC,        1, I2,        32'h8,        32'hC,        0));
      vecs.push_back(mk("redir_wait",    0, 0, 0,            0, 1, 32'h100,      0, 0,       0, 32'hC,        0, 0,         0,            0,            1));
      vecs.push_back(mk("kill_rsp",      0, 1, 32'hDEADBEEF, 0, 0, 0,            0, 0,       0, 32'h100,      0, 0,         0,            0,            0));
      vecs.push_back(mk("redir_req",     1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h100,      0, 0,         0,            0,            0));
      vecs.push_back(mk("redir_rsp",     0, 1, NOP_INSTR,    0, 0, 0,            0, 0,       0, 32'h100,      0, 0,         0,            0,            0));
      vecs.push_back(mk("trap_prio",     0, 0, 0,            0, 1, 32'h200,      1, 32'h80,  1, 32'h104,      1, NOP_INSTR, 32'h100,      32'h104,      1));
      vecs.push_back(mk("trap_req",      1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h80,       0, 0,         0,            0,            0));
      vecs.push_back(mk("trap_rsp",      0, 1, I4,           0, 0, 0,            0, 0,       0, 32'h80,       0, 0,         0,            0,            0));
      vecs.push_back(mk("align_redir",   1, 0, 0,            0, 1, 32'h103,      0, 0,       1, 32'h84,       1, I4,        32'h80,       32'h84,       1));
      vecs.push_back(mk("align_kill",    0, 1, JUNK,         0, 0, 0,            0, 0,       0, 32'h100,      0, 0,         0,            0,            0));
      vecs.push_back(mk("wrap_redir",    0, 0, 0,            0, 1, 32'hFFFFFFFC, 0, 0,       1, 32'h100,      0, 0,         0,            0,            1));
      vecs.push_back(mk("wrap_req",      1, 0, 0,            0, 0, 0,            0, 0,       1, 32'hFFFFFFFC, 0, 0,         0,            0,            0));
      vecs.push_back(mk("wrap_rsp",      0, 1, I5,           0, 0, 0,            0, 0,       0, 32'hFFFFFFFC, 0, 0,         0,            0,            0));
      vecs.push_back(mk("wrap_next",     1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h0,        1, I5,        32'hFFFFFFFC, 32'h0,        0));
      vecs.push_back(mk("pre_rst_rsp",   0, 1, I6,           0, 0, 0,            0, 0,       0, 32'h0,        0, 0,         0,            0,            0));
      vecs.push_back(mk("pre_rst_req",   1, 0, 0,            0, 0, 0,            0, 0,       1, 32'h4,        1, I6,        32'h0,        32'h4,        0));

      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.req",   imem.req,      1'b0);
      chk("rst.addr",  imem.addr,     32'h0);
      chk("rst.vld",   instr_valid_o, 1'b0);
      chk("rst.instr", instr_o,       32'h0);
      chk("rst.pc",    instr_pc_o,    32'h0);

      @(posedge clk); #1;
      reset = 1'b0;
      foreach (vecs[i]) begin
         imem.gnt = vecs[i].gnt; imem.rvalid = vecs[i].rvalid; imem.rdata = vecs[i].rdata;
         stall_d_i = vecs[i].stall; redirect_valid_i = vecs[i].redir; redirect_addr_i = vecs[i].raddr;
         trap_valid_i = vecs[i].trap; trap_addr_i = vecs[i].taddr;
         #1;
         chk({vecs[i].name, ".req"},   imem.req,      vecs[i].e_req);
         chk({vecs[i].name, ".addr"},  imem.addr,     vecs[i].e_addr);
         chk({vecs[i].name, ".vld"},   instr_valid_o, vecs[i].e_vld);
         chk({vecs[i].name, ".flush"}, flush_d_o,     vecs[i].e_flush);
         if (vecs[i].e_vld) begin
            chk({vecs[i].name, ".instr"}, instr_o,    vecs[i].e_instr);
            chk({vecs[i].name, ".pc"},    instr_pc_o, vecs[i].e_pc);
            chk({vecs[i].name, ".pc4"},   pc_plus4_o, vecs[i].e_pc4);
         end
         @(posedge clk); #1;
      end

      // Now waiting on the fetch to 0x4 with I6 left in the buffer registers
      drive_idle();
      #1;
      chk("wait.addr", imem.addr, 32'h4);
      chk("wait.req",  imem.req,  1'b0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst.req",   imem.req,      1'b0);
      chk("async_rst.addr",  imem.addr,     32'h0);
      chk("async_rst.vld",   instr_valid_o, 1'b0);
      chk("async_rst.instr", instr_o,       32'h0);
      chk("async_rst.pc",    instr_pc_o,    32'h0);
      imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      imem.rvalid = 1'b0;
      reset = 1'b0;
      #1;
      chk("post_rst.req",  imem.req,      1'b1);
      chk("post_rst.addr", imem.addr,     32'h0);
      chk("post_rst.vld",  instr_valid_o, 1'b0);
      imem.gnt = 1'b1;
      @(posedge clk); #1;
      imem.gnt = 1'b0; imem.rvalid = 1'b1; imem.rdata = I7;
      #1;
      chk("post_rst_wait.req", imem.req, 1'b0);
      @(posedge clk); #1;
      drive_idle();
      #1;
      chk("post_rst_fetch.vld",   instr_valid_o, 1'b1);
      chk("post_rst_fetch.instr", instr_o,       I7);
      chk("post_rst_fetch.pc",    instr_pc_o,    32'h0);
      chk("post_rst_fetch.pc4",   pc_plus4_o,    32'h4);
      chk("post_rst_fetch.addr",  imem.addr,     32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
